// File: rtl/mm_cmd_initiator.sv
// rtl/mm_cmd_initiator.sv - host-side command initiator for the TPM management module
//
// Takes one command at a time from the host, presents the command code and
// parameter to the management module, pulses mm_start, waits for the response
// code (or a timeout) and hands the result back over a valid/ready channel.
// Keeps saturating counters of issued commands and of failed responses.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles spent in WAIT without mm_rc_valid before a timeout (>= 2)
//   TO_W            width of the timeout counter (2**TO_W > TIMEOUT_CYCLES)
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   host_valid/host_ready         command handshake; host_cc, host_param carry the command
//   mm_tpm_cc, mm_cmd_param       command held on the management module inputs
//   mm_start                      one-cycle start pulse to the management module
//   mm_rc_valid, mm_rc            response code from the management module
//   resp_valid/resp_ready         response handshake; resp_cc, resp_rc, resp_timeout
//   busy                          high whenever the FSM is not idle
//   cmd_count, err_count          saturating command and error counters
//
// Optional feature (macro MM_BOOT_STARTUP_EN):
//   When defined, the FSM issues TPM2_Startup(SU_CLEAR) by itself after reset.
//   Its result lands in resp_* without raising resp_valid, and the FSM then
//   returns to IDLE. When undefined, the FSM goes straight to IDLE after reset.

module mm_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_cc,
    input  logic [32:0] host_param,
    output logic [31:0] mm_tpm_cc,
    output logic [32:0] mm_cmd_param,
    output logic        mm_start,
    input  logic        mm_rc_valid,
    input  logic [31:0] mm_rc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_cc,
    output logic [31:0] resp_rc,
    output logic        resp_timeout,
    output logic        busy,
    output logic [15:0] cmd_count,
    output logic [15:0] err_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
`ifdef MM_BOOT_STARTUP_EN
    localparam logic [2:0] S_BOOT  = 3'd4;
    localparam logic [2:0] S_AFTER_RESET = S_BOOT;
`else
    localparam logic [2:0] S_AFTER_RESET = S_IDLE;
`endif

    localparam logic [31:0] TPM_RC_SUCCESS = 32'h0000_0000;
    localparam logic [31:0] TPM_RC_FAILURE = 32'h0000_0101;
    localparam logic [31:0] TPM_CC_STARTUP = 32'h0000_0144;
    localparam logic [15:0] COUNT_MAX      = 16'hFFFF;
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [TO_W-1:0] to_cnt;
    // Set while the command in flight is the internally generated boot
    // command; its result must not be offered to the host.
    logic            boot_cmd;

    logic accept;
    logic timed_out;
    logic wait_done;
    logic rc_fail;

    // host_ready is only ever high in IDLE, so it also qualifies the state.
    assign accept    = host_valid && host_ready;
    assign timed_out = (to_cnt == TO_LAST);
    assign wait_done = (state == S_WAIT) && (mm_rc_valid || timed_out);
    // A real response code takes priority over a coincident timeout.
    assign rc_fail   = mm_rc_valid ? (mm_rc != TPM_RC_SUCCESS) : 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ISSUE;
                end
            end
`ifdef MM_BOOT_STARTUP_EN
            S_BOOT: begin
                state_next = S_ISSUE;
            end
`endif
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_next = boot_cmd ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs are registered from the next state so
    // that they are clean flops and read 0 throughout reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_AFTER_RESET;
            host_ready   <= 1'b0;
            busy         <= 1'b0;
            mm_start     <= 1'b0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            mm_tpm_cc    <= 32'h0;
            mm_cmd_param <= 33'h0;
            resp_cc      <= 32'h0;
            resp_rc      <= 32'h0;
            cmd_count    <= 16'h0;
            err_count    <= 16'h0;
            to_cnt       <= '0;
            boot_cmd     <= 1'b0;
        end else begin
            state      <= state_next;
            host_ready <= (state_next == S_IDLE);
            busy       <= (state_next != S_IDLE);
            mm_start   <= (state_next == S_ISSUE);
            resp_valid <= (state_next == S_RESP);

            case (state)
                S_IDLE: begin
                    boot_cmd <= 1'b0;
                    if (accept) begin
                        mm_tpm_cc    <= host_cc;
                        mm_cmd_param <= host_param;
                        resp_cc      <= host_cc;
                    end
                end
`ifdef MM_BOOT_STARTUP_EN
                S_BOOT: begin
                    // TPM2_Startup with SU_CLEAR (parameter all zero).
                    mm_tpm_cc    <= TPM_CC_STARTUP;
                    mm_cmd_param <= 33'h0;
                    resp_cc      <= TPM_CC_STARTUP;
                    boot_cmd     <= 1'b1;
                end
`endif
                S_ISSUE: begin
                    to_cnt <= '0;
                    if (cmd_count != COUNT_MAX) begin
                        cmd_count <= cmd_count + 16'd1;
                    end
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (mm_rc_valid) begin
                        resp_rc      <= mm_rc;
                        resp_timeout <= 1'b0;
                    end else if (timed_out) begin
                        resp_rc      <= TPM_RC_FAILURE;
                        resp_timeout <= 1'b1;
                    end
                    // Counted on the edge that leaves WAIT, so the new value
                    // is visible together with the captured result.
                    if (wait_done && rc_fail && (err_count != COUNT_MAX)) begin
                        err_count <= err_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mm_cmd_initiator.md
Name: mm_cmd_initiator

Overview:
- Host-side command initiator for the TPM management module.
- Accepts one command at a time from a host over a valid/ready handshake and drives the command code and parameter onto the management module command inputs. It then issues a start pulse, waits for the module's response code and returns it over a valid/ready response channel.
- Adds a response timeout plus command and error counters.
- On-board test harnesses use it in place of manual switch and key driving.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in WAIT without mm_rc_valid before a timeout is declared (must be >= 2).
- TO_W, 11: width of the timeout counter (must satisfy 2^TO_W > TIMEOUT_CYCLES).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- host_valid  input  1  host command present.
- host_ready  output  1  initiator can accept a command.
- host_cc  input  32  TPM command code.
- host_param  input  33  command parameter {handle[32:1], flag[0]}.
- mm_tpm_cc  output  32  command code to the management module.
- mm_cmd_param  output  33  parameter to the management module.
- mm_start  output  1  one-cycle start pulse to the management module.
- mm_rc_valid  input  1  management module response code valid.
- mm_rc  input  32  management module response code.
- resp_valid  output  1  response available to the host.
- resp_ready  input  1  host accepts the response.
- resp_cc  output  32  command code the response belongs to.
- resp_rc  output  32  captured response code.
- resp_timeout  output  1  response was generated by timeout.
- busy  output  1  high in every state except IDLE.
- cmd_count  output  16  commands issued, saturating.
- err_count  output  16  responses with rc != TPM_RC_SUCCESS or timeout, saturating.

Behaviour:
- Reset values (synchronous, active-high reset; outputs take these values on the first rising edge with reset=1):
  - host_ready=0, mm_start=0, resp_valid=0, resp_timeout=0, busy=0.
  - mm_tpm_cc=0, mm_cmd_param=0, resp_cc=0, resp_rc=0.
  - cmd_count=0, err_count=0.
  - State is IDLE; host_ready rises the cycle after reset deasserts.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - host_ready=1.
  - On host_valid&&host_ready, latch host_cc into mm_tpm_cc and resp_cc, latch host_param into mm_cmd_param, go to ISSUE.
- ISSUE (exactly one cycle):
  - mm_start=1.
  - cmd_count increments, saturating at 16'hFFFF.
  - Timeout counter cleared to 0; go to WAIT.
- WAIT:
  - Counter increments by 1 per cycle.
  - If mm_rc_valid=1: resp_rc<=mm_rc, resp_timeout<=0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: resp_rc<=32'h00000101 (TPM_RC_FAILURE), resp_timeout<=1, go to RESP.
  - If mm_rc_valid and the timeout condition coincide, mm_rc_valid wins.
- RESP:
  - resp_valid=1; resp_cc, resp_rc and resp_timeout are held stable.
  - On resp_ready, resp_valid drops the next cycle and the FSM returns to IDLE.
  - On the cycle RESP is entered, err_count increments (saturating) if resp_timeout=1 or resp_rc != 32'h00000000.
- Latency:
  - Handshake accepted at cycle N gives mm_start=1 at N+1.
  - mm_rc_valid at cycle M gives resp_valid=1 at M+1.
  - Minimum command-to-response latency is 3 cycles.
- mm_tpm_cc and mm_cmd_param hold the last command from ISSUE until the next accepted command; they never change during WAIT.
- mm_rc_valid outside WAIT is ignored and changes no state or counter.
- host_valid outside IDLE is not accepted because host_ready=0.
- Reset asserted mid-operation, in any state: FSM returns to IDLE, any pending response is discarded and all outputs take their reset values.
- Counters saturate at 16'hFFFF and do not wrap.

Optional Feature:
- Macro: MM_BOOT_STARTUP_EN.
- Defined:
  - After reset the FSM enters BOOT instead of IDLE.
  - BOOT loads mm_tpm_cc=32'h00000144 (TPM_CC_Startup) and mm_cmd_param=33'h0 (SU_CLEAR), then proceeds through ISSUE and WAIT as normal.
  - The result is written to resp_* but resp_valid is not asserted; the FSM returns straight to IDLE.
  - err_count increments on failure. cmd_count counts the boot command.
  - host_ready=0 during BOOT.
- Undefined: no BOOT state; the FSM goes straight to IDLE after reset.

Test Plan:
1. Reset, then host_cc=32'h144, host_param=33'h0, mm_rc_valid pulsed 5 cycles after mm_start with mm_rc=0 -> one mm_start pulse, resp_valid with resp_rc=0, resp_cc=32'h144, cmd_count=1, err_count=0.
2. Command 32'h121, mm_rc=32'h00000084 -> resp_rc=32'h84, resp_timeout=0, err_count=1.
3. No mm_rc_valid, TIMEOUT_CYCLES=16 -> resp_valid exactly 16 cycles after WAIT entry, resp_rc=32'h101, resp_timeout=1, err_count increments.
4. mm_rc_valid and timeout on the same cycle, mm_rc=0 -> resp_rc=0, resp_timeout=0; stray mm_rc_valid in IDLE -> no state change; host_valid held during WAIT -> host_ready=0 and no second mm_start.
5. resp_ready held low 20 cycles -> resp_* stable and host_ready=0; reset asserted in WAIT -> next cycle IDLE, all outputs at reset values.
6. With MM_BOOT_STARTUP_EN defined: after reset, mm_start with mm_tpm_cc=32'h144; after mm_rc=0, host_ready=1, resp_valid never asserted, cmd_count=1.
